// File: rtl/aes_pkg.sv
// Shared constants, types and helpers for the iterative AES inverse S-box.
// The GF(2^8) field and the inverse affine map are defined here once.
package aes_pkg;

    localparam logic [8:0]  GF_POLY      = 9'h11B;
    localparam logic [7:0]  INV_AFFINE_C = 8'h05;
    localparam int unsigned CHAIN_LEN    = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Inverse affine map applied before the field inversion.
    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8]
                 ^ x[(i + 7) % 8] ^ INV_AFFINE_C[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier reducing by x^8+x^4+x^3+x+1.
// Shift-and-add form; one instance is shared by every chain step.
module gf256_mul
    import aes_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] a_sh;

    // Accumulate a*x^i for each set bit of b, reducing as a is shifted.
    always_comb begin
        p    = 8'h00;
        a_sh = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ a_sh;
            end
            a_sh = {a_sh[6:0], 1'b0}
                 ^ (a_sh[7] ? GF_POLY[7:0] : 8'h00);
        end
    end

endmodule

// File: rtl/aes_inv_sbox_iter.sv
// Iterative AES inverse S-box: inverse affine, then b^254 computed by a
// 13-step square/multiply chain using a single shared GF multiplier.
module aes_inv_sbox_iter
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
);

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] base_q, base_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] mul_b;
    logic [7:0] mul_p;

    // Even steps square the accumulator, odd steps multiply by the base.
    assign mul_b = step_q[0] ? base_q : acc_q;

    gf256_mul u_mul (
        .a (acc_q),
        .b (mul_b),
        .p (mul_p)
    );

    // The accumulator holds the final power once the chain is complete.
    assign out_data = acc_q;

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        base_d    = base_q;
        acc_d     = acc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    base_d  = inv_affine(in_data);
                    acc_d   = inv_affine(in_data);
                    step_d  = 4'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = mul_p;
                if (step_q == 4'(CHAIN_LEN - 1)) begin
                    state_d = DONE;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            base_q  <= 8'h00;
            acc_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_sbox_iter.sv
// Self-checking bench for aes_inv_sbox_iter.
// Directed vectors, back-pressure, mid-op reset, full sweep, streaming.
module tb_aes_inv_sbox_iter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int checks;
    int errors;
    int cyc;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    aes_inv_sbox_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return r;
    endfunction

    // Forward S-box from brute-force inverse plus forward affine map.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] v);
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        inv = 8'h00;
        for (int k = 1; k < 256; k++) begin
            if (gmul(v, 8'(k)) == 8'h01) inv = 8'(k);
        end
        c = 8'h63;
        for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                 ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        end
        return s;
    endfunction

    // One full transaction; ready_dly negedges of back-pressure in DONE.
    task automatic run_op(input logic [7:0] din, input int ready_dly,
                          output logic [7:0] dout, output int lat,
                          output bit tmo);
        int w;
        tmo = 1'b0;
        lat = 0;
        dout = 8'h00;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            tmo = 1'b1;
            return;
        end
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) begin
            tmo = 1'b1;
            return;
        end
        dout = out_data;
        repeat (ready_dly) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b data=%h want 1 0 00",
                     in_ready, out_valid, out_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] din [6];
        logic [7:0] exp [6];
        logic [7:0] d;
        int lat;
        bit tmo;
        din = '{8'h63, 8'h7C, 8'hED, 8'hFE, 8'h00, 8'h01};
        exp = '{8'h00, 8'h01, 8'h53, 8'h0C, 8'h52, 8'h09};
        for (int i = 0; i < 6; i++) begin
            run_op(din[i], 0, d, lat, tmo);
            checks++;
            if (tmo || d !== exp[i]) begin
                errors++;
                $display("FAIL directed[%0d]: in=%h got %h want %h tmo=%b",
                         i, din[i], d, exp[i], tmo);
            end
            checks++;
            if (lat != 13) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d want 13", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        bit bad;
        w = 0;
        bad = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFE;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 5);
            in_data  = 8'h01;
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 8'h0C || in_ready !== 1'b0)
                bad = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold: vld=%b data=%h rdy=%b want 1 0c 0",
                     out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignored_in: vld=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int lat;
        bit tmo;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h7C;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
        rst_n = 1'b1;
        run_op(8'hED, 2, d, lat, tmo);
        checks++;
        if (tmo || d !== 8'h53 || lat != 13) begin
            errors++;
            $display("FAIL after_reset: got %h lat %0d want 53 lat 13",
                     d, lat);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] d;
        int lat;
        bit tmo;
        int bad;
        bad = 0;
        for (int v = 0; v < 256; v++) begin
            run_op(8'(v), int'($urandom_range(0, 3)), d, lat, tmo);
            checks++;
            if (tmo || d !== inv_tab[v] || fwd_tab[d] !== 8'(v)) begin
                errors++;
                bad++;
                if (bad < 8)
                    $display("FAIL sweep: in=%h got %h want %h", v[7:0],
                             d, inv_tab[v]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc [$];
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h52;
        for (int i = 0; i < 62; i++) begin
            @(negedge clk);
            if (in_ready) acc_cyc.push_back(cyc);
        end
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        n = acc_cyc.size();
        checks++;
        if (n < 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d want >=4", n);
        end
        for (int i = 1; i < n; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 15) begin
                errors++;
                $display("FAIL b2b_gap[%0d]: got %0d want 15", i,
                         acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        for (int v = 0; v < 256; v++) fwd_tab[v] = fwd_sbox(8'(v));
        for (int v = 0; v < 256; v++) inv_tab[fwd_tab[v]] = 8'(v);
        checks++;
        if (fwd_tab[8'h00] !== 8'h63 || fwd_tab[8'h01] !== 8'h7C) begin
            errors++;
            $display("FAIL ref_model: s(00)=%h s(01)=%h want 63 7c",
                     fwd_tab[8'h00], fwd_tab[8'h01]);
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
